// File: rtl/vrf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// vrf_write_arbiter_if
// Bundles the per-lane write requests and the single VRF write port that the
// round-robin write arbiter sits between.
//   write_req     lane -> arb   per-lane request, held until granted
//   vrf_dst_addr  lane -> arb   lane i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_recv     lane -> arb   lane i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   write_gnt     arb -> lane   one-hot, single-cycle grant pulse
//   vrf_ready     vrf -> arb    VRF can accept a write this cycle
//   vrf_we        arb -> vrf    write enable pulse
//   vrf_waddr     arb -> vrf    write address
//   vrf_wdata     arb -> vrf    write data
// The slave modport is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface vrf_write_arbiter_if #(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 1024,
   parameter int ADDR_WIDTH = 10
);
   logic [NUM_LANES-1:0]            write_req;
   logic [NUM_LANES*ADDR_WIDTH-1:0] vrf_dst_addr;
   logic [NUM_LANES*DATA_WIDTH-1:0] data_recv;
   logic [NUM_LANES-1:0]            write_gnt;
   logic                            vrf_ready;
   logic                            vrf_we;
   logic [ADDR_WIDTH-1:0]           vrf_waddr;
   logic [DATA_WIDTH-1:0]           vrf_wdata;

   modport slave (
      input  write_req,
      input  vrf_dst_addr,
      input  data_recv,
      input  vrf_ready,
      output write_gnt,
      output vrf_we,
      output vrf_waddr,
      output vrf_wdata
   );

   modport master (
      output write_req,
      output vrf_dst_addr,
      output data_recv,
      output vrf_ready,
      input  write_gnt,
      input  vrf_we,
      input  vrf_waddr,
      input  vrf_wdata
   );
endinterface

// File: rtl/vrf_write_arbiter.sv
// ---------------------------------------------------------------------------
// vrf_write_arbiter
// Round-robin arbiter for the VRF write port. Each lane holds write_req with
// its address/data until it sees a one-cycle write_gnt pulse; in that same
// cycle the arbiter drives a registered write (vrf_we/vrf_waddr/vrf_wdata).
// After each grant the FSM spends one mandatory cooldown cycle so that the
// still-high request of the lane just served is not granted twice.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    vrf_write_arbiter_if.slave (requests in, grant/VRF write out)
// ---------------------------------------------------------------------------
module vrf_write_arbiter #(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   vrf_write_arbiter_if.slave       bus
);

   localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [PTR_W-1:0]       rr_ptr_r;
   logic [PTR_W-1:0]       rr_ptr_s;
   logic [NUM_LANES-1:0]   gnt_r;
   logic [NUM_LANES-1:0]   gnt_s;
   logic                   we_r;
   logic                   we_s;
   logic [ADDR_WIDTH-1:0]  waddr_r;
   logic [ADDR_WIDTH-1:0]  waddr_s;
   logic [DATA_WIDTH-1:0]  wdata_r;
   logic [DATA_WIDTH-1:0]  wdata_s;
   int                     win_s;

   // First requesting lane searching upward from ptr with wrap-around; -1 if none.
   function automatic int pick_lane(input logic [NUM_LANES-1:0] req,
                                    input logic [PTR_W-1:0]     ptr);
      int result;
      int k;
      result = -1;
      for (int i = 0; i < NUM_LANES; i++) begin
         k = int'(ptr) + i;
         if (k >= NUM_LANES) begin
            k = k - NUM_LANES;
         end else begin
            k = k;
         end
         if ((result < 0) && req[k]) begin
            result = k;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   // Next-state and next-output logic; GRANT always falls back to ARB with outputs cleared.
   always_comb begin
      state_s  = state_r;
      rr_ptr_s = rr_ptr_r;
      gnt_s    = '0;
      we_s     = 1'b0;
      waddr_s  = waddr_r;
      wdata_s  = wdata_r;
      win_s    = pick_lane(bus.write_req, rr_ptr_r);
      case (state_r)
         ST_ARB: begin
            if (bus.vrf_ready && (win_s >= 0)) begin
               gnt_s[win_s] = 1'b1;
               we_s         = 1'b1;
               waddr_s      = bus.vrf_dst_addr[win_s*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_s      = bus.data_recv[win_s*DATA_WIDTH +: DATA_WIDTH];
               state_s      = ST_GRANT;
               if (win_s == NUM_LANES - 1) begin
                  rr_ptr_s = '0;
               end else begin
                  rr_ptr_s = PTR_W'(win_s + 1);
               end
            end else begin
               state_s = ST_ARB;
            end
         end
         ST_GRANT: begin
            state_s = ST_ARB;
         end
         default: begin
            state_s = ST_ARB;
         end
      endcase
   end

   // State, pointer and registered VRF write outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_ARB;
         rr_ptr_r <= '0;
         gnt_r    <= '0;
         we_r     <= 1'b0;
         waddr_r  <= '0;
         wdata_r  <= '0;
      end else begin
         state_r  <= state_s;
         rr_ptr_r <= rr_ptr_s;
         gnt_r    <= gnt_s;
         we_r     <= we_s;
         waddr_r  <= waddr_s;
         wdata_r  <= wdata_s;
      end
   end

   assign bus.write_gnt = gnt_r;
   assign bus.vrf_we    = we_r;
   assign bus.vrf_waddr = waddr_r;
   assign bus.vrf_wdata = wdata_r;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vrf_write_arbiter
// Directed bench for the VRF write arbiter: single grant, round-robin order,
// wrap-around, cooldown, backpressure and reset in the middle of a grant.
// ---------------------------------------------------------------------------
module tb_vrf_write_arbiter;

   localparam int NL = 4;
   localparam int DW = 1024;
   localparam int AW = 10;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [7:0]    lane_byte [NL];
   logic [AW-1:0] lane_addr [NL];

   vrf_write_arbiter_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   vrf_write_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] lane_data(input int i);
      return {128{lane_byte[i]}};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      int w;
      w = 0;
      for (int i = DW/32 - 1; i >= 0; i--) begin
         if (obs[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      end
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s word=%0d observed=%h expected=%h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
      end
   endtask

   // lane < 0 means no grant expected in this cycle
   task automatic check_grant(input string tag, input int lane);
      logic [NL-1:0] exp_gnt;
      exp_gnt = '0;
      if (lane >= 0) exp_gnt[lane] = 1'b1;
      check({tag, "_gnt"}, 64'(bus.write_gnt), 64'(exp_gnt));
      check({tag, "_we"}, 64'(bus.vrf_we), (lane >= 0) ? 64'd1 : 64'd0);
      if (lane >= 0) begin
         check({tag, "_addr"}, 64'(bus.vrf_waddr), 64'(lane_addr[lane]));
         check_data({tag, "_data"}, bus.vrf_wdata, lane_data(lane));
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      lane_byte[0] = 8'h10; lane_byte[1] = 8'h21; lane_byte[2] = 8'hA5; lane_byte[3] = 8'h3C;
      lane_addr[0] = 10'h001; lane_addr[1] = 10'h0AA; lane_addr[2] = 10'h155; lane_addr[3] = 10'h3FF;
      rst_n          = 1'b0;
      bus.write_req  = '0;
      bus.vrf_ready  = 1'b0;
      for (int i = 0; i < NL; i++) begin
         bus.vrf_dst_addr[i*AW +: AW] = lane_addr[i];
         bus.data_recv[i*DW +: DW]    = lane_data(i);
      end

      // Reset state
      at_neg(); at_neg();
      check_grant("reset", -1);
      check("reset_addr", 64'(bus.vrf_waddr), 64'd0);
      check_data("reset_data", bus.vrf_wdata, '0);
      check("reset_ptr", 64'(dut.rr_ptr_r), 64'd0);
      rst_n = 1'b1;

      // 1. Single lane 2
      at_neg(); bus.write_req = 4'b0100; bus.vrf_ready = 1'b1;
      at_pos(); check_grant("t1", 2);
      check("t1_ptr", 64'(dut.rr_ptr_r), 64'd3);
      at_neg(); bus.write_req = 4'b0000;
      at_pos(); check_grant("t1_idle", -1);
      check("t1_hold_addr", 64'(bus.vrf_waddr), 64'h155);

      // 2. All lanes from reset; each lane drops after the cooldown edge
      at_neg(); rst_n = 1'b0;
      at_neg(); rst_n = 1'b1; bus.write_req = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         at_pos(); check_grant($sformatf("t2_lane%0d", c), c);
         at_pos(); check_grant($sformatf("t2_gap%0d", c), -1);
         at_neg(); bus.write_req[c] = 1'b0;
      end
      check("t2_ptr", 64'(dut.rr_ptr_r), 64'd0);

      // 3. Wrap: grant lane 2, then lanes 0 and 3 -> 3 first, then 0
      bus.write_req = 4'b0100;
      at_pos(); check_grant("t3_l2", 2);
      at_pos(); check_grant("t3_gap0", -1);
      at_neg(); bus.write_req = 4'b1001;
      at_pos(); check_grant("t3_l3", 3);
      at_pos(); check_grant("t3_gap1", -1);
      at_neg(); bus.write_req = 4'b0001;
      at_pos(); check_grant("t3_l0", 0);
      at_pos(); check_grant("t3_gap2", -1);
      at_neg(); bus.write_req = 4'b0000;

      // 4. Cooldown: lane 1 holds request one cycle past its grant
      bus.write_req = 4'b0010;
      at_pos(); check_grant("t4_l1", 1);
      at_pos(); check_grant("t4_cool", -1);
      at_neg(); bus.write_req = 4'b0000;
      at_pos(); check_grant("t4_after", -1);
      check("t4_ptr", 64'(dut.rr_ptr_r), 64'd2);

      // 5. Backpressure with lane 0 requesting
      at_neg(); bus.vrf_ready = 1'b0; bus.write_req = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         at_pos(); check_grant($sformatf("t5_bp%0d", c), -1);
      end
      at_neg(); bus.vrf_ready = 1'b1;
      at_pos(); check_grant("t5_l0", 0);
      at_neg(); bus.write_req = 4'b0000; bus.vrf_ready = 1'b0;
      at_pos(); check_grant("t5_idle", -1);

      // 6. Reset while lane 1 is granted
      at_neg(); bus.vrf_ready = 1'b1; bus.write_req = 4'b0010;
      at_pos(); check_grant("t6_l1", 1);
      #2 rst_n = 1'b0;
      #1;
      check_grant("t6_rst", -1);
      check("t6_rst_addr", 64'(bus.vrf_waddr), 64'd0);
      check_data("t6_rst_data", bus.vrf_wdata, '0);
      check("t6_rst_ptr", 64'(dut.rr_ptr_r), 64'd0);
      at_neg(); rst_n = 1'b1; bus.write_req = 4'b0011;
      at_pos(); check_grant("t6_l0", 0);
      at_neg(); bus.write_req = 4'b0000;
      at_pos(); check_grant("t6_idle", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
